// File: rtl/m68k_bus_master.sv
// Single-master MC68000 asynchronous bus cycle engine: one host request becomes one S0..S7 bus cycle.
// Strobes and handshakes are registered decodes of the cycle state and trail it by one clock.
module m68k_bus_master #(
    parameter int TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ,
    input  logic        WE,
    input  logic [23:1] ADDR,
    input  logic [15:0] WDATA,
    input  logic [1:0]  BE,
    output logic        ACK,
    output logic        BERR,
    output logic [15:0] RDATA,
    output logic        BUSY,
    output logic [23:1] A,
    output logic        A_OE,
    output logic [15:0] D_OUT,
    output logic        D_OE,
    input  logic [15:0] D_IN,
    output logic        _AS,
    output logic        _UDS,
    output logic        _LDS,
    output logic        _PRW,
    input  logic        _DTACK
);

    typedef enum logic [3:0] {IDLE, S0, S1, S2, S3, S4, W, S5, S6, S7} state_t;

    localparam logic [6:0] TMO = 7'(TIMEOUT);

    state_t      state_r, state_s;
    logic        we_r;
    logic [23:1] addr_r;
    logic [15:0] wdata_r;
    logic [1:0]  be_r;
    logic        sync1_r, sync2_r;
    logic [6:0]  wcnt_r, wcnt_s;
    logic        abort_r, abort_s;
    logic        gap_r;
    logic        accept_s;
    logic        as_s, ds_rd_s, ds_wr_s, ds_s, prw_win_s, doe_win_s;

    // Next-state logic, wait counting and timeout abort
    always_comb begin
        state_s  = state_r;
        wcnt_s   = wcnt_r;
        abort_s  = abort_r;
        accept_s = 1'b0;
        case (state_r)
            IDLE: begin
                // gap_r holds off a new cycle for one clock after S7
                if (REQ && !gap_r) begin
                    accept_s = 1'b1;
                    state_s  = S0;
                end else begin
                    state_s  = IDLE;
                end
            end
            S0: begin
                state_s = S1;
                wcnt_s  = 7'd0;
                abort_s = 1'b0;
            end
            S1: state_s = S2;
            S2: state_s = S3;
            S3: state_s = S4;
            S4: begin
                wcnt_s = wcnt_r + 7'd1;
                if (!sync2_r) begin
                    state_s = S5;
                end else if (wcnt_r >= TMO) begin
                    state_s = S7;
                    abort_s = 1'b1;
                end else begin
                    state_s = W;
                end
            end
            W: begin
                wcnt_s  = wcnt_r + 7'd1;
                state_s = S4;
            end
            S5: state_s = S6;
            S6: state_s = S7;
            S7: state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Per-state strobe windows
    always_comb begin
        as_s      = 1'b0;
        ds_rd_s   = 1'b0;
        ds_wr_s   = 1'b0;
        prw_win_s = 1'b0;
        doe_win_s = 1'b0;
        case (state_r)
            S1: prw_win_s = 1'b1;
            S2: begin
                prw_win_s = 1'b1;
                as_s      = 1'b1;
                ds_rd_s   = 1'b1;
            end
            S3: begin
                prw_win_s = 1'b1;
                as_s      = 1'b1;
                ds_rd_s   = 1'b1;
                doe_win_s = 1'b1;
            end
            S4, W, S5, S6: begin
                prw_win_s = 1'b1;
                as_s      = 1'b1;
                ds_rd_s   = 1'b1;
                ds_wr_s   = 1'b1;
                doe_win_s = 1'b1;
            end
            S7: begin
                prw_win_s = 1'b1;
                doe_win_s = 1'b1;
            end
            default: as_s = 1'b0;
        endcase
        ds_s = we_r ? ds_wr_s : ds_rd_s;
    end

    // State, request capture and _DTACK synchronizer
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
            we_r    <= 1'b0;
            addr_r  <= 23'd0;
            wdata_r <= 16'd0;
            be_r    <= 2'b00;
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            wcnt_r  <= 7'd0;
            abort_r <= 1'b0;
            gap_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            sync1_r <= _DTACK;
            sync2_r <= sync1_r;
            wcnt_r  <= wcnt_s;
            abort_r <= abort_s;
            gap_r   <= (state_r == S7);
            if (accept_s) begin
                we_r    <= WE;
                addr_r  <= ADDR;
                wdata_r <= WDATA;
                be_r    <= (BE == 2'b00) ? 2'b11 : BE;
            end
        end
    end

    // Registered bus and host outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            _AS   <= 1'b1;
            _UDS  <= 1'b1;
            _LDS  <= 1'b1;
            _PRW  <= 1'b1;
            A_OE  <= 1'b0;
            D_OE  <= 1'b0;
            A     <= 23'd0;
            D_OUT <= 16'd0;
            ACK   <= 1'b0;
            BERR  <= 1'b0;
            BUSY  <= 1'b0;
            RDATA <= 16'd0;
        end else begin
            _AS   <= ~as_s;
            _UDS  <= ~(be_r[1] & ds_s);
            _LDS  <= ~(be_r[0] & ds_s);
            _PRW  <= ~(we_r & prw_win_s);
            A_OE  <= (state_r != IDLE);
            A     <= (state_r != IDLE) ? addr_r : A;
            D_OE  <= we_r & doe_win_s;
            D_OUT <= (we_r & doe_win_s) ? wdata_r : D_OUT;
            ACK   <= (state_r == S7) & ~abort_r;
            BERR  <= (state_r == S7) & abort_r;
            // stays high until the trailing S7 outputs have been presented
            BUSY  <= (state_r != IDLE) | accept_s;
            if (state_r == S7 && !we_r && !abort_r) begin
                RDATA <= D_IN;
            end
        end
    end

endmodule

// File: tb/tb_m68k_bus_master.sv
// Self-checking bench for m68k_bus_master: per-cycle strobe/handshake counts are scoreboarded
// against expectations queued when each cycle is launched.
module tb_m68k_bus_master;

    logic        CLK = 1'b0;
    logic        RST, REQ, WE;
    logic [23:1] ADDR;
    logic [15:0] WDATA;
    logic [1:0]  BE;
    logic        ACK, BERR, BUSY, A_OE, D_OE;
    logic [15:0] RDATA, D_OUT, D_IN;
    logic [23:1] A;
    logic        _AS, _UDS, _LDS, _PRW, _DTACK;

    typedef struct packed {
        logic [7:0] busy;
        logic [7:0] as_low;
        logic [7:0] uds;
        logic [7:0] lds;
        logic [7:0] prw;
        logic [7:0] doe;
        logic [7:0] acks;
        logic [7:0] berrs;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    exp_t        mon = '0;
    logic [15:0] exp_rdata;
    logic [15:0] din_at_as = 16'd0;
    logic [15:0] dout_last = 16'd0;
    logic [2:0]  strb_at_berr = 3'b000;
    int          both_cnt = 0;
    int          low_run = 0;
    int          last_gap = 0;
    logic        prev_busy = 1'b0;

    always #5 CLK = ~CLK;

    m68k_bus_master #(.TIMEOUT(8)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .WE(WE), .ADDR(ADDR), .WDATA(WDATA), .BE(BE),
        .ACK(ACK), .BERR(BERR), .RDATA(RDATA), .BUSY(BUSY), .A(A), .A_OE(A_OE),
        .D_OUT(D_OUT), .D_OE(D_OE), .D_IN(D_IN),
        ._AS(_AS), ._UDS(_UDS), ._LDS(_LDS), ._PRW(_PRW), ._DTACK(_DTACK)
    );

    // Bus observer, sampled mid-cycle on the falling edge
    always @(negedge CLK) begin
        if (BUSY)  mon.busy   <= mon.busy + 8'd1;
        if (!_AS)  mon.as_low <= mon.as_low + 8'd1;
        if (!_UDS) mon.uds    <= mon.uds + 8'd1;
        if (!_LDS) mon.lds    <= mon.lds + 8'd1;
        if (!_PRW) mon.prw    <= mon.prw + 8'd1;
        if (D_OE)  mon.doe    <= mon.doe + 8'd1;
        if (ACK)   mon.acks   <= mon.acks + 8'd1;
        if (BERR)  mon.berrs  <= mon.berrs + 8'd1;
        if (!_AS)  din_at_as  <= D_IN;
        if (D_OE)  dout_last  <= D_OUT;
        if (BERR)  strb_at_berr <= {_AS, _UDS, _LDS};
        if (ACK && BERR) both_cnt <= both_cnt + 1;
        if (!BUSY) begin
            low_run <= low_run + 1;
        end else begin
            if (!prev_busy) last_gap <= low_run;
            low_run <= 0;
        end
        prev_busy <= BUSY;
    end

    function automatic exp_t delta(input exp_t a, input exp_t b);
        exp_t d;
        d.busy   = a.busy - b.busy;
        d.as_low = a.as_low - b.as_low;
        d.uds    = a.uds - b.uds;
        d.lds    = a.lds - b.lds;
        d.prw    = a.prw - b.prw;
        d.doe    = a.doe - b.doe;
        d.acks   = a.acks - b.acks;
        d.berrs  = a.berrs - b.berrs;
        return d;
    endfunction

    task automatic pulse_req(input logic we, input logic [23:1] addr, input logic [15:0] wd, input logic [1:0] be);
        @(posedge CLK); #1;
        WE = we; ADDR = addr; WDATA = wd; BE = be; REQ = 1'b1;
        @(posedge CLK); #1;
        REQ = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (BUSY && n < 200) begin
            @(posedge CLK); #1;
            n++;
        end
        repeat (3) @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; REQ = 1'b0; WE = 1'b0; ADDR = 23'd0; WDATA = 16'd0; BE = 2'b00;
        D_IN = 16'd0; _DTACK = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if ({_AS, _UDS, _LDS, _PRW} !== 4'b1111) begin
            errors++; $display("FAIL reset_strobes: got %b required 1111", {_AS, _UDS, _LDS, _PRW});
        end
        checks++;
        if ({A_OE, D_OE, ACK, BERR, BUSY} !== 5'b00000) begin
            errors++; $display("FAIL reset_ctrl: got %b required 00000", {A_OE, D_OE, ACK, BERR, BUSY});
        end
        checks++;
        if ({A, D_OUT, RDATA} !== 55'd0) begin
            errors++; $display("FAIL reset_data: got A=%h D_OUT=%h RDATA=%h required all 0", A, D_OUT, RDATA);
        end
        RST = 1'b0;
        exp_rdata = 16'd0;
        repeat (2) @(posedge CLK);
        #1;
    endtask

    task automatic test_read();
        exp_t base, got, e;
        int   lat;
        _DTACK = 1'b0; D_IN = 16'h1234;
        sb.push_back({8'd9, 8'd5, 8'd5, 8'd5, 8'd0, 8'd0, 8'd1, 8'd0});
        exp_rdata = 16'h1234;
        base = mon;
        pulse_req(1'b0, 23'h7C0000, 16'h0000, 2'b11);
        checks++;
        if (BUSY !== 1'b1) begin
            errors++; $display("FAIL read_busy_start: got %b required 1", BUSY);
        end
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge CLK); #1;
            if (ACK) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat !== 8) begin
            errors++; $display("FAIL read_latency: got %0d required 8", lat);
        end
        checks++;
        if ({A_OE, A} !== {1'b1, 23'h7C0000}) begin
            errors++; $display("FAIL read_addr: got oe=%b A=%h required oe=1 A=7c0000", A_OE, A);
        end
        wait_idle();
        got = delta(mon, base);
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
            errors++; $display("FAIL read_counts: got %h required %h", got, e);
        end
        checks++;
        if (RDATA !== exp_rdata) begin
            errors++; $display("FAIL read_rdata: got %h required %h", RDATA, exp_rdata);
        end
    endtask

    task automatic test_write(input logic [1:0] be, input logic [15:0] wd, input logic [7:0] uds, input logic [7:0] lds);
        exp_t base, got, e;
        _DTACK = 1'b0;
        sb.push_back({8'd9, 8'd5, uds, lds, 8'd7, 8'd5, 8'd1, 8'd0});
        base = mon;
        pulse_req(1'b1, 23'h001234, wd, be);
        wait_idle();
        got = delta(mon, base);
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
            errors++; $display("FAIL write_counts be=%b: got %h required %h", be, got, e);
        end
        checks++;
        if (dout_last !== wd) begin
            errors++; $display("FAIL write_dout: got %h required %h", dout_last, wd);
        end
        checks++;
        if (RDATA !== exp_rdata) begin
            errors++; $display("FAIL write_rdata_hold: got %h required %h", RDATA, exp_rdata);
        end
    endtask

    task automatic test_wait_states();
        exp_t base, got, e;
        int   n_as;
        _DTACK = 1'b1; D_IN = 16'hA000;
        sb.push_back({8'd17, 8'd13, 8'd13, 8'd13, 8'd0, 8'd0, 8'd1, 8'd0});
        base = mon;
        pulse_req(1'b0, 23'h000100, 16'h0000, 2'b11);
        n_as = -1;
        for (int i = 0; i < 60; i++) begin
            @(posedge CLK); #1;
            D_IN = D_IN + 16'h0101;
            if (n_as < 0 && !_AS) n_as = 0;
            else if (n_as >= 0) n_as++;
            if (n_as == 6) _DTACK = 1'b0;
            if (ACK) break;
        end
        _DTACK = 1'b1;
        wait_idle();
        got = delta(mon, base);
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
            errors++; $display("FAIL wait_counts: got %h required %h", got, e);
        end
        checks++;
        if (got.busy < 8'd11 || got.busy[0] !== 1'b1) begin
            errors++; $display("FAIL wait_pairing: got %0d busy clocks required odd and > 9", got.busy);
        end
        exp_rdata = din_at_as;
        checks++;
        if (RDATA !== exp_rdata) begin
            errors++; $display("FAIL wait_rdata: got %h required %h", RDATA, exp_rdata);
        end
    endtask

    task automatic test_timeout();
        exp_t base, got, e;
        _DTACK = 1'b1; D_IN = 16'hDEAD;
        sb.push_back({8'd15, 8'd11, 8'd11, 8'd11, 8'd0, 8'd0, 8'd0, 8'd1});
        base = mon;
        pulse_req(1'b0, 23'h000200, 16'h0000, 2'b11);
        wait_idle();
        got = delta(mon, base);
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
            errors++; $display("FAIL timeout_counts: got %h required %h", got, e);
        end
        checks++;
        if (RDATA !== exp_rdata) begin
            errors++; $display("FAIL timeout_rdata_hold: got %h required %h", RDATA, exp_rdata);
        end
        checks++;
        if (strb_at_berr !== 3'b111) begin
            errors++; $display("FAIL timeout_strobes: got %b required 111", strb_at_berr);
        end
    endtask

    task automatic test_reset_mid();
        exp_t base, got, e;
        int   n;
        _DTACK = 1'b1; D_IN = 16'h7777;
        base = mon;
        pulse_req(1'b0, 23'h000300, 16'h0000, 2'b11);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK); #1;
            if (!_AS) n++;
            if (n == 3) break;
        end
        RST = 1'b1;
        @(posedge CLK); #1;
        checks++;
        if ({_AS, _UDS, _LDS, _PRW, BUSY, ACK, BERR} !== 7'b1111000) begin
            errors++; $display("FAIL midreset_outputs: got %b required 1111000", {_AS, _UDS, _LDS, _PRW, BUSY, ACK, BERR});
        end
        checks++;
        if (RDATA !== 16'd0) begin
            errors++; $display("FAIL midreset_rdata: got %h required 0000", RDATA);
        end
        RST = 1'b0;
        exp_rdata = 16'd0;
        repeat (12) @(posedge CLK);
        #1;
        got = delta(mon, base);
        checks++;
        if ({got.acks, got.berrs} !== 16'd0) begin
            errors++; $display("FAIL midreset_no_handshake: got ack=%0d berr=%0d required 0 0", got.acks, got.berrs);
        end
        _DTACK = 1'b0; D_IN = 16'h5A5A;
        sb.push_back({8'd9, 8'd5, 8'd5, 8'd5, 8'd0, 8'd0, 8'd1, 8'd0});
        exp_rdata = 16'h5A5A;
        base = mon;
        pulse_req(1'b0, 23'h000304, 16'h0000, 2'b11);
        wait_idle();
        got = delta(mon, base);
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
            errors++; $display("FAIL after_reset_counts: got %h required %h", got, e);
        end
        checks++;
        if (RDATA !== exp_rdata) begin
            errors++; $display("FAIL after_reset_rdata: got %h required %h", RDATA, exp_rdata);
        end
    endtask

    task automatic test_back_to_back();
        exp_t base, got;
        int   acks;
        _DTACK = 1'b0; D_IN = 16'h3C3C;
        exp_rdata = 16'h3C3C;
        base = mon;
        @(posedge CLK); #1;
        WE = 1'b0; BE = 2'b11; ADDR = 23'h000AAA; REQ = 1'b1;
        acks = 0;
        for (int i = 1; i < 80; i++) begin
            @(posedge CLK); #1;
            if (i == 3) ADDR = 23'h000555;
            if (ACK) begin
                acks++;
                checks++;
                if (A !== ((acks == 1) ? 23'h000AAA : 23'h000555)) begin
                    errors++; $display("FAIL b2b_addr cycle %0d: got %h", acks, A);
                end
                if (acks == 2) begin
                    REQ = 1'b0;
                    break;
                end
            end
        end
        REQ = 1'b0;
        wait_idle();
        got = delta(mon, base);
        checks++;
        if (got.acks !== 8'd2) begin
            errors++; $display("FAIL b2b_acks: got %0d required 2", got.acks);
        end
        checks++;
        if (last_gap !== 1) begin
            errors++; $display("FAIL b2b_idle_gap: got %0d required 1", last_gap);
        end
        base = mon;
        pulse_req(1'b0, 23'h0123AB, 16'h0000, 2'b11);
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK); #1;
            REQ = ~REQ;
            ADDR = ADDR + 23'd1;
            if (ACK) begin
                REQ = 1'b0;
                checks++;
                if (A !== 23'h0123AB) begin
                    errors++; $display("FAIL toggle_addr: got %h required 0123ab", A);
                end
                break;
            end
        end
        REQ = 1'b0;
        wait_idle();
        repeat (4) @(posedge CLK);
        #1;
        got = delta(mon, base);
        checks++;
        if ({got.busy, got.acks} !== {8'd9, 8'd1}) begin
            errors++; $display("FAIL toggle_single_cycle: got busy=%0d acks=%0d required 9 1", got.busy, got.acks);
        end
        checks++;
        if (RDATA !== exp_rdata) begin
            errors++; $display("FAIL b2b_rdata: got %h required %h", RDATA, exp_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write(2'b01, 16'hBEEF, 8'd0, 8'd3);
        test_write(2'b00, 16'h0F0F, 8'd3, 8'd3);
        test_wait_states();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (both_cnt !== 0) begin
            errors++; $display("FAIL ack_berr_overlap: got %0d required 0", both_cnt);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/m68k_bus_master.md
M68K_BUS_MASTER -- requirements
Module: m68k_bus_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, meaning the maximum number of clocks spent in S4/W without _DTACK before the cycle aborts.
REQ-002 SHALL have port CLK, input, 1, the single clock, one clock per 68000 S-state; all logic rising-edge.
REQ-003 SHALL have port RST, input, 1, synchronous active-high reset.
REQ-004 SHALL have port REQ, input, 1, host cycle request, sampled only in IDLE.
REQ-005 SHALL have port WE, input, 1, 1=write, 0=read; captured with REQ.
REQ-006 SHALL have port ADDR, input, 23 [23:1], word address; captured with REQ.
REQ-007 SHALL have port WDATA, input, 16, write data; captured with REQ.
REQ-008 SHALL have port BE, input, 2, byte enables, [1]=upper, [0]=lower; captured with REQ.
REQ-009 SHALL have port ACK, output, 1, one-clock pulse marking successful completion.
REQ-010 SHALL have port BERR, output, 1, one-clock pulse marking timeout abort.
REQ-011 SHALL have port RDATA, output, 16, latched read data.
REQ-012 SHALL have port BUSY, output, 1, high in any state other than IDLE.
REQ-013 SHALL have port A, output, 23 [23:1], bus address, with A_OE (output, 1) as its drive enable.
REQ-014 SHALL have port D_OUT, output, 16, bus write data, with D_OE (output, 1) as its drive enable.
REQ-015 SHALL have port D_IN, input, 16, bus read data.
REQ-016 SHALL have ports _AS, _UDS, _LDS, _PRW, each output, 1, 68000 strobes, active-low except _PRW (1=read).
REQ-017 SHALL have port _DTACK, input, 1, asynchronous, active-low.

Function
REQ-018 States SHALL be IDLE, S0, S1, S2, S3, S4, W, S5, S6, S7, advancing one state per clock unless stated otherwise.
REQ-019 IDLE with REQ=1 SHALL capture WE/ADDR/WDATA/BE and enter S0 on the next edge; REQ in any other state SHALL be ignored.
REQ-020 BE=00 SHALL be treated as BE=11.
REQ-021 _DTACK SHALL pass through a 2-flop synchronizer; "DTACK seen" means synchronized value 0.
REQ-022 In S4: DTACK seen goes to S5; otherwise W. W SHALL return to S4 unconditionally, so waits are inserted in 2-clock pairs.
REQ-023 A 7-bit wait counter SHALL clear in S0 and increment each clock in S4/W; reaching TIMEOUT while in S4 without DTACK seen SHALL go to S7 with abort flagged.
REQ-024 A and A_OE SHALL be valid/high from S0 through S7.
REQ-025 _PRW SHALL be 0 from S1 through S7 for writes and 1 otherwise.
REQ-026 _AS SHALL be 0 in S2..S6, including S4/W.
REQ-027 On reads, enabled _UDS/_LDS SHALL be 0 in S2..S6.
REQ-028 On writes, enabled _UDS/_LDS SHALL be 0 in S4..S6 (including W).
REQ-029 D_OUT SHALL equal captured WDATA, with D_OE=1 in S3..S7, for writes only.
REQ-030 On the edge leaving S6 of a read, RDATA SHALL load all 16 bits of D_IN; RDATA SHALL otherwise hold, including on abort.
REQ-031 ACK=1 only during S7 of a non-aborted cycle; BERR=1 only during S7 of an aborted cycle; the two are never both high.
REQ-032 S7 SHALL always go to IDLE, with a minimum of one IDLE clock between cycles.
REQ-033 Zero-wait latency: REQ sampled at edge k gives ACK high in the cycle after edge k+8, 9 BUSY clocks total.

Reset
REQ-034 RST=1 SHALL force the following values on the next edge, from any state, mid-cycle included: IDLE; _AS=_UDS=_LDS=_PRW=1; A_OE=D_OE=0; A=0; D_OUT=0; ACK=BERR=BUSY=0; RDATA=0; wait counter=0; synchronizer flops=1.
REQ-035 A cycle interrupted by reset SHALL produce no ACK or BERR.

Verification
REQ-036 Read, _DTACK tied 0, D_IN=16'h1234, ADDR=23'h7C0000, BE=11 -> _AS low 5 clocks; ACK exactly once; RDATA=16'h1234; BUSY 9 clocks.
REQ-037 Write, WDATA=16'hBEEF, BE=01, _DTACK tied 0 -> _PRW low S1..S7; _UDS stays 1; _LDS low 3 clocks; D_OE high 5 clocks; D_OUT=16'hBEEF; ACK once.
REQ-038 Read, _DTACK asserted 6 clocks after _AS falls -> waits inserted in pairs; total clocks even-offset from 9; RDATA = D_IN at S6; ACK once.
REQ-039 _DTACK held 1, TIMEOUT=8 -> BERR single pulse, no ACK; RDATA unchanged from prior value; strobes negated in S7.
REQ-040 RST pulsed during W of a read -> next clock all strobes 1, BUSY=0, no ACK/BERR; a following REQ completes normally.
REQ-041 REQ held high across two cycles, and REQ toggled while BUSY -> exactly two cycles, one IDLE clock between; mid-cycle REQ changes ignored.
